// File: rtl/cam_pixel_capture.sv
// OV7670 camera front-end: synchronises the raw camera bus into clk, assembles
// RGB565 byte pairs into pixel strobes with row/column tags, and flags frame edges.
module cam_pixel_capture #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [7:0]       cam_d,
  input  logic             cam_pclk,
  input  logic             cam_href,
  input  logic             cam_vsync,
  output logic             pix_valid,
  output logic [4:0]       pix_r,
  output logic [5:0]       pix_g,
  output logic [4:0]       pix_b,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             frame_start,
  output logic             frame_end,
  output logic [ROW_W-1:0] frame_lines,
  output logic             byte_err
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_VBLANK    = 2'd1,
    ST_LINE_WAIT = 2'd2,
    ST_IN_LINE   = 2'd3
  } state_t;

  // Synchroniser chains: meta flop, stable flop, and a delayed copy for edge detection.
  logic       r_pclk_m, r_pclk_s, r_pclk_d;
  logic       r_href_m, r_href_s, r_href_d;
  logic       r_vsync_m, r_vsync_s, r_vsync_d;
  logic [7:0] r_d_m, r_d_s;

  state_t r_state, w_state_nxt;

  logic             r_phase;
  logic [7:0]       r_hi;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  logic             r_pix_valid;
  logic [4:0]       r_pix_r;
  logic [5:0]       r_pix_g;
  logic [4:0]       r_pix_b;
  logic [COL_W-1:0] r_pix_col;
  logic [ROW_W-1:0] r_pix_row;
  logic             r_frame_start;
  logic             r_frame_end;
  logic [ROW_W-1:0] r_frame_lines;
  logic             r_byte_err;

  logic w_pclk_rise, w_href_rise, w_href_fall, w_vsync_rise, w_vsync_fall;
  logic w_frame_begin, w_frame_close, w_partial, w_line_begin, w_line_close, w_byte_take;
  logic w_pixel_done, w_phase_after, w_odd_end;
  logic [COL_W-1:0] w_col_inc;
  logic [ROW_W-1:0] w_row_inc;

  // NOTE: every flop uses <= so all of them sample pre-edge values; blocking
  // assignments here would collapse the synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pclk_m  <= 1'b0;
      r_pclk_s  <= 1'b0;
      r_pclk_d  <= 1'b0;
      r_href_m  <= 1'b0;
      r_href_s  <= 1'b0;
      r_href_d  <= 1'b0;
      r_vsync_m <= 1'b0;
      r_vsync_s <= 1'b0;
      r_vsync_d <= 1'b0;
      r_d_m     <= 8'h00;
      r_d_s     <= 8'h00;
    end else if (ena) begin
      r_pclk_m  <= cam_pclk;
      r_pclk_s  <= r_pclk_m;
      r_pclk_d  <= r_pclk_s;
      r_href_m  <= cam_href;
      r_href_s  <= r_href_m;
      r_href_d  <= r_href_s;
      r_vsync_m <= cam_vsync;
      r_vsync_s <= r_vsync_m;
      r_vsync_d <= r_vsync_s;
      r_d_m     <= cam_d;
      r_d_s     <= r_d_m;
    end
  end

  // Data travels through the same two-flop depth as pclk, so it is aligned with w_pclk_rise.
  assign w_pclk_rise  = r_pclk_s & ~r_pclk_d;
  assign w_href_rise  = r_href_s & ~r_href_d;
  assign w_href_fall  = ~r_href_s & r_href_d;
  assign w_vsync_rise = r_vsync_s & ~r_vsync_d;
  assign w_vsync_fall = ~r_vsync_s & r_vsync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= ST_IDLE;
    else if (ena) r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:      if (r_vsync_s) w_state_nxt = ST_VBLANK;
      ST_VBLANK:    if (w_vsync_fall) w_state_nxt = ST_LINE_WAIT;
      ST_LINE_WAIT: begin
        if (w_vsync_rise)     w_state_nxt = ST_VBLANK;
        else if (w_href_rise) w_state_nxt = ST_IN_LINE;
      end
      ST_IN_LINE: begin
        if (w_vsync_rise)     w_state_nxt = ST_VBLANK;
        else if (w_href_fall) w_state_nxt = ST_LINE_WAIT;
      end
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: each signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_frame_begin = 1'b0;
    w_frame_close = 1'b0;
    w_partial     = 1'b0;
    w_line_begin  = 1'b0;
    w_line_close  = 1'b0;
    w_byte_take   = 1'b0;
    unique case (r_state)
      ST_VBLANK:    w_frame_begin = w_vsync_fall;
      ST_LINE_WAIT: begin
        w_frame_close = w_vsync_rise;
        w_line_begin  = w_href_rise & ~w_vsync_rise;
      end
      ST_IN_LINE: begin
        // A byte landing in the same cycle as the href fall still belongs to the line.
        w_byte_take   = w_pclk_rise & (r_href_s | w_href_fall);
        w_frame_close = w_vsync_rise;
        w_partial     = w_vsync_rise;
        w_line_close  = w_href_fall & ~w_vsync_rise;
      end
      default: ;
    endcase
  end

  assign w_pixel_done  = w_byte_take & r_phase;
  assign w_phase_after = r_phase ^ w_byte_take;
  assign w_odd_end     = (w_line_close | w_partial) & w_phase_after;
  assign w_col_inc     = (&r_col) ? r_col : r_col + COL_W'(1);
  assign w_row_inc     = (&r_row) ? r_row : r_row + ROW_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_hi    <= 8'h00;
      r_col   <= '0;
      r_row   <= '0;
    end else if (ena) begin
      if (w_line_begin || w_line_close || w_frame_close) r_phase <= 1'b0;
      else if (w_byte_take)                               r_phase <= ~r_phase;

      if (w_byte_take && !r_phase) r_hi <= r_d_s;

      if (w_line_begin)      r_col <= '0;
      else if (w_pixel_done) r_col <= w_col_inc;

      if (w_frame_begin)     r_row <= '0;
      else if (w_line_close) r_row <= w_row_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_valid   <= 1'b0;
      r_pix_r       <= '0;
      r_pix_g       <= '0;
      r_pix_b       <= '0;
      r_pix_col     <= '0;
      r_pix_row     <= '0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      r_frame_lines <= '0;
      r_byte_err    <= 1'b0;
    end else if (ena) begin
      r_pix_valid   <= w_pixel_done;
      r_frame_start <= w_frame_begin;
      r_frame_end   <= w_frame_close;
      if (w_pixel_done) begin
        r_pix_r   <= r_hi[7:3];
        r_pix_g   <= {r_hi[2:0], r_d_s[7:5]};
        r_pix_b   <= r_d_s[4:0];
        r_pix_col <= r_col;
        r_pix_row <= r_row;
      end
      // A vsync rise mid-line closes the partial line before reporting the count.
      if (w_frame_close) r_frame_lines <= w_partial ? w_row_inc : r_row;
      if (w_frame_begin)  r_byte_err <= 1'b0;
      else if (w_odd_end) r_byte_err <= 1'b1;
    end
  end

  // Strobes are masked while frozen so a held pulse cannot be seen twice.
  assign pix_valid   = r_pix_valid & ena;
  assign frame_start = r_frame_start & ena;
  assign frame_end   = r_frame_end & ena;
  assign pix_r       = r_pix_r;
  assign pix_g       = r_pix_g;
  assign pix_b       = r_pix_b;
  assign pix_col     = r_pix_col;
  assign pix_row     = r_pix_row;
  assign frame_lines = r_frame_lines;
  assign byte_err    = r_byte_err;

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench for cam_pixel_capture: stimulus pushes expected pixels and
// frame events into queues; a negedge monitor pops and compares on each strobe.
module tb_cam_pixel_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] cam_d;
  logic       cam_pclk, cam_href, cam_vsync;
  logic       pix_valid, frame_start, frame_end, byte_err;
  logic [4:0] pix_r, pix_b;
  logic [5:0] pix_g;
  logic [9:0] pix_col;
  logic [8:0] pix_row, frame_lines;

  cam_pixel_capture #(.COL_W(10), .ROW_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cam_d(cam_d), .cam_pclk(cam_pclk),
    .cam_href(cam_href), .cam_vsync(cam_vsync), .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_col(pix_col),
    .pix_row(pix_row), .frame_start(frame_start), .frame_end(frame_end),
    .frame_lines(frame_lines), .byte_err(byte_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] hi; logic [7:0] lo; int r; int g; int b; } vec_t;
  typedef struct { int r; int g; int b; int col; int row; int cyc; } pix_t;
  typedef struct { bit is_end; int lines; bit err; } ev_t;

  vec_t vec [11];
  pix_t pix_q [$];
  ev_t  ev_q  [$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: strobe with nothing expected (cycle %0d)", name, cyc);
  endtask

  // Monitor: pixel and frame strobes, each checked for content and one-cycle width.
  initial begin
    bit   prev_pv = 1'b0, prev_fs = 1'b0, prev_fe = 1'b0;
    pix_t p;
    ev_t  e;
    forever begin
      @(negedge clk);
      if (prev_pv) check("pix_width", pix_valid, 0);
      if (prev_fs) check("start_width", frame_start, 0);
      if (prev_fe) check("end_width", frame_end, 0);
      if (pix_valid && !prev_pv) begin
        if (pix_q.size() == 0) flag_unexpected("pix_unexpected");
        else begin
          p = pix_q.pop_front();
          check("pix_r", pix_r, p.r);
          check("pix_g", pix_g, p.g);
          check("pix_b", pix_b, p.b);
          check("pix_col", pix_col, p.col);
          check("pix_row", pix_row, p.row);
          check("pix_latency", cyc, p.cyc);
        end
      end
      if (frame_start && !prev_fs) begin
        if (ev_q.size() == 0) flag_unexpected("start_unexpected");
        else begin
          e = ev_q.pop_front();
          check("start_kind", 0, e.is_end);
          check("start_byte_err", byte_err, e.err);
        end
      end
      if (frame_end && !prev_fe) begin
        if (ev_q.size() == 0) flag_unexpected("end_unexpected");
        else begin
          e = ev_q.pop_front();
          check("end_kind", 1, e.is_end);
          check("end_lines", frame_lines, e.lines);
          check("end_byte_err", byte_err, e.err);
        end
      end
      prev_pv = pix_valid;
      prev_fs = frame_start;
      prev_fe = frame_end;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pclk = clk/4: two cycles low with data set, then two cycles high.
  task automatic send_byte(input logic [7:0] b, output int rise_cyc);
    tick(1);
    cam_d    = b;
    cam_pclk = 1'b0;
    tick(2);
    cam_pclk = 1'b1;
    rise_cyc = cyc;
    tick(1);
  endtask

  // The strobe is visible in the 4th clock counting the one holding the raw rise.
  task automatic send_pixel(input int idx, input int col, input int row);
    int   rc;
    pix_t p;
    send_byte(vec[idx].hi, rc);
    send_byte(vec[idx].lo, rc);
    p = '{r: vec[idx].r, g: vec[idx].g, b: vec[idx].b, col: col, row: row, cyc: rc + 3};
    pix_q.push_back(p);
  endtask

  task automatic line_begin();
    tick(1);
    cam_href = 1'b1;
    tick(2);
  endtask

  task automatic line_end();
    tick(1);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(5);
  endtask

  task automatic frame_open();
    ev_t e;
    cam_vsync = 1'b1;
    tick(6);
    e = '{is_end: 1'b0, lines: 0, err: 1'b0};
    ev_q.push_back(e);
    cam_vsync = 1'b0;
    tick(6);
  endtask

  task automatic frame_close(input int lines, input bit err);
    ev_t e;
    e = '{is_end: 1'b1, lines: lines, err: err};
    ev_q.push_back(e);
    cam_vsync = 1'b1;
    tick(6);
  endtask

  initial begin
    int rc;
    vec[0]  = '{8'hF8, 8'h00, 31,  0,  0};
    vec[1]  = '{8'h07, 8'hE0,  0, 63,  0};
    vec[2]  = '{8'h12, 8'h34,  2, 17, 20};
    vec[3]  = '{8'hAB, 8'hCD, 21, 30, 13};
    vec[4]  = '{8'hFF, 8'hFF, 31, 63, 31};
    vec[5]  = '{8'h00, 8'h01,  0,  0,  1};
    vec[6]  = '{8'h5A, 8'hA5, 11, 21,  5};
    vec[7]  = '{8'h80, 8'h1F, 16,  0, 31};
    vec[8]  = '{8'hC3, 8'h3C, 24, 25, 28};
    vec[9]  = '{8'hE7, 8'h18, 28, 56, 24};
    vec[10] = '{8'h36, 8'hC9,  6, 54,  9};

    rst_n = 1'b0; ena = 1'b1;
    cam_d = 8'h00; cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0;

    // 1: reset with camera pins toggling, then a line before any vsync.
    for (int i = 0; i < 8; i++) begin
      tick(1);
      cam_pclk  = ~cam_pclk;
      cam_href  = i[1];
      cam_vsync = i[2];
      cam_d     = 8'hA0 + 8'(i);
      if (i % 3 == 0)
        check("reset_outputs", {pix_valid, frame_start, frame_end, byte_err, pix_r, pix_g,
                                pix_b, pix_col, pix_row, frame_lines}, 0);
    end
    cam_pclk = 1'b0; cam_href = 1'b0; cam_vsync = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(4);
    line_begin();
    send_byte(8'h11, rc);
    send_byte(8'h22, rc);
    line_end();
    frame_open();

    // 2: one line F8,00,07,E0.
    line_begin();
    send_pixel(0, 0, 0);
    send_pixel(1, 1, 0);
    line_end();
    frame_close(1, 1'b0);

    // 3: three lines of two pixels.
    frame_open();
    for (int ln = 0; ln < 3; ln++) begin
      line_begin();
      send_pixel(2 + 2 * ln, 0, ln);
      send_pixel(3 + 2 * ln, 1, ln);
      line_end();
    end
    frame_close(3, 1'b0);

    // 4: three-byte line; the odd byte rises together with the href fall.
    frame_open();
    line_begin();
    send_pixel(9, 0, 0);
    tick(1);
    cam_d    = 8'h99;
    cam_pclk = 1'b0;
    tick(2);
    cam_pclk = 1'b1;
    cam_href = 1'b0;
    tick(6);
    check("odd_line_err", byte_err, 1);
    cam_pclk = 1'b0;
    tick(2);
    frame_close(1, 1'b1);
    check("err_in_vblank", byte_err, 1);
    frame_open();
    check("err_after_start", byte_err, 0);

    // 5: pclk edges with href low, then a pixel split around ena low.
    send_byte(8'h3E, rc);
    send_byte(8'h4F, rc);
    cam_pclk = 1'b0;
    tick(4);
    line_begin();
    send_byte(vec[10].hi, rc);
    tick(3);
    ena = 1'b0;
    tick(10);
    ena = 1'b1;
    begin
      pix_t p;
      send_byte(vec[10].lo, rc);
      p = '{r: vec[10].r, g: vec[10].g, b: vec[10].b, col: 0, row: 0, cyc: rc + 3};
      pix_q.push_back(p);
    end
    send_pixel(8, 1, 0);
    tick(4);

    // 6: reset after one byte of a line; nothing until a new vsync high->low.
    send_byte(8'h12, rc);
    tick(1);
    rst_n = 1'b0;
    #1;
    check("midline_reset_outputs", {pix_valid, frame_start, frame_end, byte_err, pix_r, pix_g,
                                    pix_b, pix_col, pix_row, frame_lines}, 0);
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    line_begin();
    send_byte(8'h55, rc);
    send_byte(8'h66, rc);
    line_end();
    frame_open();
    line_begin();
    send_pixel(7, 0, 0);
    line_end();
    frame_close(1, 1'b0);

    tick(10);
    check("pix_queue_drained", pix_q.size(), 0);
    check("event_queue_drained", ev_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cam_pixel_capture.md
Name: cam_pixel_capture

Overview:
Front-end for the OV7670 camera bus. It synchronises the asynchronous PCLK/HREF/VSYNC/D[7:0] signals into clk. It assembles RGB565 byte pairs into one-cycle pixel strobes that carry row and column coordinates. It also emits frame start and end pulses. The output feeds the feature-extraction and BNN stage, which then no longer samples raw camera pins.

Parameters:
COL_W, 10, width of column counter (pixels per line, saturating)
ROW_W, 9, width of row counter (lines per frame, saturating)

Ports:
clk  input  1  system clock; camera PCLK must be ≤ clk/4
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state
cam_d  input  8  camera data bus D[7:0], asynchronous
cam_pclk  input  1  camera pixel clock, asynchronous
cam_href  input  1  line valid, asynchronous
cam_vsync  input  1  frame sync (high = vertical blank), asynchronous
pix_valid  output  1  one-cycle strobe, pixel fields valid
pix_r  output  5  red component
pix_g  output  6  green component
pix_b  output  5  blue component
pix_col  output  COL_W  column index of the pixel (0-based)
pix_row  output  ROW_W  row index of the pixel (0-based)
frame_start  output  1  one-cycle pulse at frame begin
frame_end  output  1  one-cycle pulse at frame end
frame_lines  output  ROW_W  line count of the last completed frame
byte_err  output  1  sticky: line ended on an odd byte; cleared at frame_start

Behaviour:
- Reset: all outputs 0; FSM = IDLE; counters, byte phase and synchroniser flops = 0.
- Reset is asynchronous; all logic is clocked on clk rising edge. Reset mid-frame discards the partial pixel and returns to IDLE with no pulses.
- Synchronisers: cam_pclk, cam_href, cam_vsync and cam_d each pass through 2 flops (pclk_s, href_s, vsync_s, d_s). pclk_s goes through one more flop (pclk_d).
- pclk_rise = pclk_s & ~pclk_d. Edges of href_s and vsync_s are detected the same way against their own delayed copies.
- ena low: no registers update. pix_valid, frame_start and frame_end are forced 0.
- FSM states:
  - IDLE: wait for vsync_s high. Entered from reset.
  - VBLANK: vsync_s high. On vsync_s fall → LINE_WAIT; frame_start=1 next cycle; row=0; byte_err cleared.
  - LINE_WAIT: in frame, href_s low. On href_s rise → IN_LINE; col=0; byte phase=0.
  - IN_LINE: on each pclk_rise with href_s high:
    - phase 0: store d_s as high byte; phase←1.
    - phase 1: pix_r=hi[7:3], pix_g={hi[2:0],d_s[7:5]}, pix_b=d_s[4:0]; pix_col=col; pix_row=row; pix_valid=1 on the next cycle; col←col+1 (saturate at all-ones); phase←0.
    - On href_s fall → LINE_WAIT; row←row+1 (saturate); if phase=1, set byte_err and drop the half pixel.
  - From LINE_WAIT or IN_LINE, vsync_s rise → VBLANK, with frame_end=1 next cycle and frame_lines←row. A vsync rise during IN_LINE first counts the partial line: frame_lines=row+1 (saturating), and byte_err is set if phase=1.
- pclk_rise while href_s low is ignored. In IDLE/VBLANK all pclk and href activity is ignored, so no pixels are emitted before the first vsync fall after reset.
- Latency: pix_valid rises exactly 1 clk after the pclk_rise cycle of the second byte. That is 4 clk after a raw cam_pclk rise that satisfies setup to clk.
- Pixel fields hold their value until the next pix_valid. frame_lines holds until the next frame_end.
- Simultaneous href_s fall and pclk_rise in the same cycle: process the byte first, then the line end.

Test Plan:
1. Reset with inputs toggling → all outputs 0; no pix_valid/frame_start until vsync goes high then low; then exactly one frame_start pulse.
2. One line of 4 bytes F8,00,07,E0 (vsync low, href high, pclk = clk/4) → two pix_valid strobes: (r=31,g=0,b=0,col=0,row=0) and (r=0,g=63,b=0,col=1,row=0); each strobe 1 clk wide, 4 clk after its raw pclk rise.
3. Frame of 3 lines × 2 pixels, then vsync rise → 6 strobes, rows 0..2; frame_end single pulse; frame_lines=3; byte_err=0.
4. Line of 3 bytes → 1 pixel emitted, byte_err=1 after href fall; byte_err stays 1 until the next frame_start, then 0.
5. pclk edges with href low, and a pixel whose bytes are split around ena low for 10 clk → no spurious pixels; the pixel completes correctly after ena returns with unchanged col/row.
6. Assert rst_n low mid-line after one byte → outputs 0 immediately; after release, no pixel until a new vsync high→low; col/row restart at 0.
